// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding valid/ready request, fixed access latency,
// byte-enabled stores committed at acceptance, loads read on entry to the response state.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// WAIT  | request captured, counting down the access latency
// RESP  | rsp_valid high, holding the response until rsp_ready
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   idx_q;
  logic            we_q;
  logic            err_q;
  logic [AW-1:0]   req_idx;
  logic            req_err;
  logic            accept;
  logic            rsp_done;
  logic            enter_resp;

  assign req_idx    = req_addr[AW+1:2];
  // Full word index is compared, so out-of-range addresses never alias onto storage.
  assign req_err    = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= DEPTH_W);
  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESP);
  assign accept     = req_valid && req_ready;
  assign rsp_done   = rsp_valid && rsp_ready;
  assign enter_resp = (state == WAIT) && (cnt == 4'd0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        idx_q <= req_idx;
        we_q  <= req_we;
        err_q <= req_err;
      end
      if (enter_resp) begin
        rsp_err   <= err_q;
        rsp_rdata <= (we_q || err_q) ? 32'd0 : mem[idx_q];
      end else if (rsp_done) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= 32'd0;
      end
    end
  end

  // Storage is deliberately left out of reset so a committed store survives it.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 2, 1, 15) on one clock,
// hand-computed expectations checked inline in one task per scenario.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .DEPTH  (64),
      .LATENCY((g == 0) ? 2 : (g == 1) ? 1 : 15)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we   (req_we[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .req_be   (req_be[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g])
    );
  end

  // Present a request and wait for acceptance; returns after the accept edge (+#1).
  task automatic issue(input int d, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    int k;
    req_we[d]    = we;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_be[d]    = be;
    req_valid[d] = 1'b1;
    k = 0;
    while (!req_ready[d] && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
  endtask

  // Full transaction: lat = edges from acceptance until rsp_valid seen (-1 on timeout).
  task automatic txn(input int d, input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be,
                     output logic [31:0] rd, output logic e, output int lat);
    issue(d, we, a, wd, be);
    lat = 0;
    while (!rsp_valid[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid[d]) lat = -1;
    rd = rsp_rdata[d];
    e  = rsp_err[d];
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0;   req_be[d] = '0;   rsp_ready[d] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (req_ready[0] !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready[0]); end
    n_cmp++; if (rsp_valid[0] !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid[0]); end
    n_cmp++; if (rsp_rdata[0] !== 32'd0) begin n_bad++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata[0]); end
    n_cmp++; if (rsp_err[0] !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err[0]); end
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rsp_valid[0] !== 1'b0) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL idle_no_rsp: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic e; int lat;
    txn(0, 1'b1, 32'd100, 32'd25, 4'hF, rd, e, lat);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL store_latency: got %0d want 2", lat); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL store_err: got %b want 0", e); end
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL store_rdata: got %h want 0", rd); end
    n_cmp++; if (rsp_valid[0] !== 1'b0) begin n_bad++; $display("FAIL store_handshake: rsp_valid got %b want 0", rsp_valid[0]); end
    txn(0, 1'b0, 32'd100, 32'd0, 4'h0, rd, e, lat);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL load_latency: got %0d want 2", lat); end
    n_cmp++; if (rd !== 32'd25) begin n_bad++; $display("FAIL load_rdata: got %h want 19", rd); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL load_err: got %b want 0", e); end
  endtask

  task automatic test_byte_enables();
    logic [31:0] rd; logic e; int lat;
    txn(0, 1'b1, 32'd96, 32'h11223344, 4'hF, rd, e, lat);
    txn(0, 1'b1, 32'd96, 32'hAABBCCDD, 4'b0101, rd, e, lat);
    txn(0, 1'b0, 32'd96, 32'd0, 4'h0, rd, e, lat);
    n_cmp++; if (rd !== 32'h11BB33DD) begin n_bad++; $display("FAIL byte_enable_merge: got %h want 11bb33dd", rd); end
    txn(0, 1'b1, 32'd100, 32'hFFFFFFFF, 4'h0, rd, e, lat);
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL be_zero_err: got %b want 0", e); end
    txn(0, 1'b0, 32'd100, 32'd0, 4'h0, rd, e, lat);
    n_cmp++; if (rd !== 32'd25) begin n_bad++; $display("FAIL be_zero_noop: got %h want 19", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e; int lat;
    txn(0, 1'b1, 32'd98, 32'hFFFFFFFF, 4'hF, rd, e, lat);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL misaligned_err: got %b want 1", e); end
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL misaligned_rdata: got %h want 0", rd); end
    txn(0, 1'b0, 32'd256, 32'd0, 4'h0, rd, e, lat);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL range_err: got %b want 1", e); end
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL range_rdata: got %h want 0", rd); end
    txn(0, 1'b1, 32'd352, 32'h12345678, 4'hF, rd, e, lat);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL range_store_err: got %b want 1", e); end
    txn(0, 1'b0, 32'd96, 32'd0, 4'h0, rd, e, lat);
    n_cmp++; if (rd !== 32'h11BB33DD) begin n_bad++; $display("FAIL err_store_untouched96: got %h want 11bb33dd", rd); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL err_store_untouched96_err: got %b want 0", e); end
    txn(0, 1'b0, 32'd252, 32'd0, 4'h0, rd, e, lat);
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL last_word_err: got %b want 0", e); end
    txn(0, 1'b0, 32'd100, 32'd0, 4'h0, rd, e, lat);
    n_cmp++; if (rd !== 32'd25) begin n_bad++; $display("FAIL err_store_untouched100: got %h want 19", rd); end
  endtask

  task automatic test_backpressure();
    int k;
    issue(0, 1'b0, 32'd100, 32'd0, 4'h0);
    k = 0;
    while (!rsp_valid[0] && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    req_we[0] = 1'b0; req_addr[0] = 32'd96; req_valid[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (rsp_valid[0] !== 1'b1) begin n_bad++; $display("FAIL bp_valid c%0d: got %b want 1", c, rsp_valid[0]); end
      n_cmp++; if (rsp_rdata[0] !== 32'd25) begin n_bad++; $display("FAIL bp_rdata c%0d: got %h want 19", c, rsp_rdata[0]); end
      n_cmp++; if (rsp_err[0] !== 1'b0) begin n_bad++; $display("FAIL bp_err c%0d: got %b want 0", c, rsp_err[0]); end
      n_cmp++; if (req_ready[0] !== 1'b0) begin n_bad++; $display("FAIL bp_req_ready c%0d: got %b want 0", c, req_ready[0]); end
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    n_cmp++; if (rsp_valid[0] !== 1'b0) begin n_bad++; $display("FAIL bp_done_valid: got %b want 0", rsp_valid[0]); end
    n_cmp++; if (req_ready[0] !== 1'b1) begin n_bad++; $display("FAIL bp_done_req_ready: got %b want 1", req_ready[0]); end
    n_cmp++; if (rsp_rdata[0] !== 32'd0) begin n_bad++; $display("FAIL bp_done_rdata: got %h want 0", rsp_rdata[0]); end
    k = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rsp_valid[0] !== 1'b0) k++;
    end
    n_cmp++; if (k !== 0) begin n_bad++; $display("FAIL bp_second_not_taken: got %0d valid cycles want 0", k); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic e; int lat; int seen;
    txn(0, 1'b1, 32'd200, 32'hCAFEF00D, 4'hF, rd, e, lat);
    issue(0, 1'b1, 32'd204, 32'h0BADBEEF, 4'hF);
    reset = 1'b1;
    #1;
    n_cmp++; if (rsp_valid[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", rsp_valid[0]); end
    n_cmp++; if (req_ready[0] !== 1'b1) begin n_bad++; $display("FAIL midrst_req_ready: got %b want 1", req_ready[0]); end
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rsp_valid[0] !== 1'b0) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_no_rsp: got %0d valid cycles want 0", seen); end
    txn(0, 1'b0, 32'd200, 32'd0, 4'h0, rd, e, lat);
    n_cmp++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL midrst_keep200: got %h want cafef00d", rd); end
    txn(0, 1'b0, 32'd204, 32'd0, 4'h0, rd, e, lat);
    n_cmp++; if (rd !== 32'h0BADBEEF) begin n_bad++; $display("FAIL midrst_keep204: got %h want 0badbeef", rd); end
  endtask

  task automatic test_latency(input int d, input int want);
    logic [31:0] rd; logic e; int lat;
    txn(d, 1'b1, 32'd100, 32'h5A5A1234, 4'hF, rd, e, lat);
    n_cmp++; if (lat !== want) begin n_bad++; $display("FAIL lat%0d_store: got %0d want %0d", want, lat, want); end
    txn(d, 1'b0, 32'd100, 32'd0, 4'h0, rd, e, lat);
    n_cmp++; if (lat !== want) begin n_bad++; $display("FAIL lat%0d_load: got %0d want %0d", want, lat, want); end
    n_cmp++; if (rd !== 32'h5A5A1234) begin n_bad++; $display("FAIL lat%0d_rdata: got %h want 5a5a1234", want, rd); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_enables();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_latency(1, 1);
    test_latency(2, 15);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
